// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync-FIFO write port between two producers.
// Rejected writes are retried a bounded number of times, then dropped and counted.
module fifo_wr_arbiter #(
  parameter int DATA_W    = 16,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [DATA_W-1:0] fifo_data_in,
  output logic              fifo_wr_en,
  input  logic              fifo_full,
  input  logic              fifo_wr_ack,
  input  logic              fifo_overflow,
  output logic              grant_id,
  output logic              busy,
  output logic              drop_pulse,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CHECK = 2'd2,
    RETRY = 2'd3
  } state_t;

  state_t              state_r;
  logic                last_grant_r;
  logic [RETRY_W-1:0]  retry_cnt_r;
  logic [DATA_W-1:0]   fifo_data_in_r;
  logic                fifo_wr_en_r;
  logic                grant_id_r;
  logic                busy_r;
  logic                drop_pulse_r;
  logic [CNT_W-1:0]    drop_count_r;

  logic                grant0_s;
  logic                grant1_s;
  logic                idle_open_s;
  logic                accept0_s;
  logic                accept1_s;
  logic                reject_s;

  // Round-robin grant selection and the combinational ready path
  always_comb begin
    grant0_s    = 1'b0;
    grant1_s    = 1'b0;
    idle_open_s = 1'b0;
    reject_s    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0_s = last_grant_r;
      grant1_s = !last_grant_r;
    end else begin
      grant0_s = req0_valid;
      grant1_s = req1_valid;
    end
    idle_open_s = (state_r == IDLE) && !fifo_full && !rst;
    // ack wins over overflow; overflow and a silent non-ack are both retried
    reject_s = !fifo_wr_ack && (fifo_overflow || !fifo_overflow);
  end

  assign accept0_s  = idle_open_s & grant0_s & req0_valid;
  assign accept1_s  = idle_open_s & grant1_s & req1_valid;
  assign req0_ready = idle_open_s & grant0_s;
  assign req1_ready = idle_open_s & grant1_s;

  // Arbiter FSM with all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      last_grant_r   <= 1'b1;
      retry_cnt_r    <= {RETRY_W{1'b0}};
      fifo_data_in_r <= {DATA_W{1'b0}};
      fifo_wr_en_r   <= 1'b0;
      grant_id_r     <= 1'b0;
      busy_r         <= 1'b0;
      drop_pulse_r   <= 1'b0;
      drop_count_r   <= {CNT_W{1'b0}};
    end else begin
      fifo_wr_en_r <= 1'b0;
      drop_pulse_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept0_s || accept1_s) begin
            fifo_data_in_r <= accept1_s ? req1_data : req0_data;
            grant_id_r     <= accept1_s;
            last_grant_r   <= accept1_s;
            retry_cnt_r    <= {RETRY_W{1'b0}};
            fifo_wr_en_r   <= 1'b1;
            busy_r         <= 1'b1;
            state_r        <= WRITE;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        WRITE: begin
          state_r <= CHECK;
        end
        CHECK: begin
          if (!reject_s) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (retry_cnt_r < RETRY_MAX) begin
            retry_cnt_r <= retry_cnt_r + RETRY_W'(1);
            state_r     <= RETRY;
          end else begin
            drop_pulse_r <= 1'b1;
            if (drop_count_r != {CNT_W{1'b1}}) begin
              drop_count_r <= drop_count_r + CNT_W'(1);
            end
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RETRY: begin
          // the held word and grant_id are reused unchanged for the next attempt
          if (!fifo_full) begin
            fifo_wr_en_r <= 1'b1;
            state_r      <= WRITE;
          end else begin
            state_r <= RETRY;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign fifo_data_in = fifo_data_in_r;
  assign fifo_wr_en   = fifo_wr_en_r;
  assign grant_id     = grant_id_r;
  assign busy         = busy_r;
  assign drop_pulse   = drop_pulse_r;
  assign drop_count   = drop_count_r;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the 16-bit sync FIFO write port between two producers.
- Accepts one word per valid/ready handshake, issues it to the FIFO as a one-cycle write, and checks the FIFO's registered wr_ack/overflow response.
- On a rejected write it retries a bounded number of times, then drops the word and counts the drop.
- Sits between producer blocks and the FIFO write side; the read side is untouched.

Parameters:
- DATA_W, 16, word width; must match the FIFO data_in width.
- MAX_RETRY, 3, retries after the first rejected attempt (MAX_RETRY+1 attempts total).
- CNT_W, 8, width of drop_count.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  producer 0 has a word.
- req0_data  input  DATA_W  producer 0 word; stable while req0_valid=1 and not accepted.
- req0_ready  output  1  producer 0 word accepted when req0_valid & req0_ready.
- req1_valid  input  1  producer 1 has a word.
- req1_data  input  DATA_W  producer 1 word.
- req1_ready  output  1  producer 1 accept.
- fifo_data_in  output  DATA_W  to FIFO data_in; registered.
- fifo_wr_en  output  1  to FIFO wr_en; registered, one-cycle pulse per attempt.
- fifo_full  input  1  from FIFO full.
- fifo_wr_ack  input  1  from FIFO wr_ack; registered in the FIFO one cycle after wr_en.
- fifo_overflow  input  1  from FIFO overflow; same timing as wr_ack.
- grant_id  output  1  source of the word in flight; registered.
- busy  output  1  high in every state except IDLE.
- drop_pulse  output  1  one-cycle pulse when a word is discarded.
- drop_count  output  CNT_W  saturating count of dropped words.

Behaviour:
- Reset values: fifo_wr_en=0, fifo_data_in=0, grant_id=0, busy=0, drop_pulse=0, drop_count=0, retry_cnt=0, last_grant=1 (so req0 wins first), state=IDLE. Ready outputs are 0 during reset.
- States: IDLE, WRITE, CHECK, RETRY.
- IDLE:
  - Ready is combinational: reqN_ready = (state==IDLE) & !fifo_full & grantN.
  - Only one valid: grant that requester.
  - Both valid: grant the requester that is not last_grant.
  - On a handshake: capture data into the hold register, set grant_id, update last_grant, clear retry_cnt, go to WRITE.
  - No handshake while fifo_full=1.
- WRITE: fifo_wr_en=1 and fifo_data_in=hold for exactly one cycle; next state is CHECK.
- CHECK: fifo_wr_en=0; sample fifo_wr_ack and fifo_overflow.
  - wr_ack=1: go to IDLE (success). A new accept is possible on that IDLE cycle, so throughput is at most 1 word per 3 cycles.
  - Otherwise (overflow=1, or neither asserted):
    - retry_cnt<MAX_RETRY: retry_cnt++, go to RETRY.
    - Else: drop_pulse=1 next cycle, drop_count++ saturating at all-ones, go to IDLE.
- RETRY: hold until fifo_full=0, then go to WRITE with the same data and grant_id.
- Latency: accept at edge N, fifo_wr_en high in cycle N+1, result sampled in cycle N+2.
- No new requester is accepted while busy=1. Ordering per requester is preserved.
- A requester dropping valid before ready is legal; no grant is consumed and last_grant is unchanged.
- wr_ack and overflow both high in CHECK is treated as success.
- Reset mid-operation returns everything to reset values. The held word is lost and is not counted as a drop.
- drop_count does not wrap. drop_pulse never asserts for more than one consecutive cycle.

Test Plan:
- Single requester: req0_valid=1, data 0xA5A5, FIFO empty -> req0_ready=1 in the accept cycle; fifo_wr_en=1 with 0xA5A5 next cycle; wr_ack seen in CHECK; busy low 3 cycles after accept.
- Fairness: both valid continuously, data 0x1111/0x2222, FIFO never full -> accepted order 0x1111, 0x2222, 0x1111, 0x2222; grant_id alternates 0,1,0,1.
- Full blocking: fifo_full=1 with both valid -> both ready=0 and fifo_wr_en=0 indefinitely; release full -> req0 accepted first after reset.
- Retry then success: model returns overflow on the first attempt, full deasserts 2 cycles later -> RETRY holds, second fifo_wr_en carries the same word, wr_ack -> IDLE with drop_count=0.
- Exhaustion: overflow forced on every attempt, MAX_RETRY=3 -> exactly 4 fifo_wr_en pulses, then one drop_pulse, drop_count=1, return to IDLE; repeat 256 times with CNT_W=8 -> drop_count saturates at 255.
- Reset mid-flight: assert rst during RETRY -> all outputs return to reset values asynchronously; after release, req0 wins a simultaneous request.
